// File: rtl/fuzz_pkg.sv
// fuzz_pkg: shared arbiter state type, default parameters
// and the cyclic index increment helper.
package fuzz_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  function automatic int wrap_inc(input int i,
                                  input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/fuzz_rr_picker.sv
// fuzz_rr_picker: combinational round-robin pick. Ports:
// req_valid, rr_ptr in; idx (first set bit at/after rr_ptr), found out.
module fuzz_rr_picker
  import fuzz_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IW      = (NUM_REQ > 1) ?
                          $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IW-1:0]      rr_ptr,
  output logic [IW-1:0]      idx,
  output logic               found
);

  int          c;
  logic [IW-1:0] ci;

  // Walk offsets high to low so the smallest
  // offset from rr_ptr is the one left standing.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    c     = 0;
    ci    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      c = int'(rr_ptr) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      ci = IW'(c);
      if (req_valid[ci]) begin
        idx   = ci;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fuzz_master_arbiter.sv
// fuzz_master_arbiter: round-robin arbiter of req_* onto one ext_master_*
// bus; busy flags non-IDLE. FUZZ_ARB_TIMEOUT_EN adds a WAIT timeout (req_err).
module fuzz_master_arbiter
  import fuzz_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic [NUM_REQ-1:0]    req_done,
  output logic [NUM_REQ-1:0]    req_err,
  output logic [DATA_WIDTH-1:0] req_rdata,
  output logic                  ext_master_req,
  output logic                  ext_master_we,
  output logic [ADDR_WIDTH-1:0] ext_master_addr_read,
  output logic [ADDR_WIDTH-1:0] ext_master_addr_write,
  output logic [DATA_WIDTH-1:0] ext_master_wdata,
  input  logic [DATA_WIDTH-1:0] ext_master_rdata,
  input  logic                  ext_master_read_done,
  input  logic                  ext_master_write_done,
  output logic                  busy
);

  localparam int IW = (NUM_REQ > 1) ?
                      $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || TIMEOUT_CYCLES < 1)
  begin : g_bad_cfg
    $error("NUM_REQ and TIMEOUT_CYCLES must be >= 1");
  end

  arb_state_t state, state_nx;

  logic [IW-1:0]         rr_ptr;
  logic [IW-1:0]         owner;
  logic [IW-1:0]         pick_idx;
  logic                  pick_found;
  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  cmpl;
  logic                  timeout;
  logic                  active;
  logic [NUM_REQ-1:0]    owner_oh;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

`ifdef FUZZ_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          to_flag;
`endif

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  =
        req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_arr[i] =
        req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  fuzz_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .idx       (pick_idx),
    .found     (pick_found)
  );

  // Only the done matching the captured
  // direction completes the transfer.
  always_comb begin
    state_nx = state;
    cmpl     = cap_we ? ext_master_write_done
                      : ext_master_read_done;
    timeout  = 1'b0;
`ifdef FUZZ_ARB_TIMEOUT_EN
    timeout  = (state == WAIT) && !cmpl &&
               (to_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif
    unique case (state)
      IDLE:  if (pick_found) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT:  if (cmpl || timeout) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && pick_found) begin
        owner     <= pick_idx;
        cap_we    <= req_we[pick_idx];
        cap_addr  <= addr_arr[pick_idx];
        cap_wdata <= wdata_arr[pick_idx];
      end
      if (state == WAIT && !cap_we &&
          ext_master_read_done)
        rdata_q <= ext_master_rdata;
      if (state == DONE)
        rr_ptr <= IW'(wrap_inc(int'(owner),
                               NUM_REQ));
    end
  end

`ifdef FUZZ_ARB_TIMEOUT_EN
  // to_flag holds the exit reason of the
  // last WAIT so DONE knows which pulse to give.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else if (state == WAIT) begin
      to_cnt  <= to_cnt + 1'b1;
      to_flag <= timeout;
    end else begin
      to_cnt  <= '0;
    end
  end
`endif

  assign active   = (state == ISSUE) ||
                    (state == WAIT);
  assign owner_oh = NUM_REQ'(1) << owner;
  assign busy     = (state != IDLE);

  assign ext_master_req        = active;
  assign ext_master_we         = active & cap_we;
  assign ext_master_addr_read  = active ? cap_addr : '0;
  assign ext_master_addr_write = active ? cap_addr : '0;
  assign ext_master_wdata      = active ? cap_wdata : '0;

  assign req_grant = busy ? owner_oh : '0;
  assign req_rdata = rdata_q;

`ifdef FUZZ_ARB_TIMEOUT_EN
  assign req_done = (state == DONE && !to_flag) ?
                    owner_oh : '0;
  assign req_err  = (state == DONE && to_flag) ?
                    owner_oh : '0;
`else
  assign req_done = (state == DONE) ? owner_oh : '0;
  assign req_err  = '0;
`endif

endmodule

// File: tb/tb_fuzz_master_arbiter.sv
// tb_fuzz_master_arbiter: scoreboard bench for fuzz_master_arbiter;
// define FUZZ_ARB_TIMEOUT_EN to also cover the timeout path.
module tb_fuzz_master_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_we;
  logic [127:0] req_addr, req_wdata;
  logic [3:0]   req_grant, req_done, req_err;
  logic [31:0]  req_rdata;
  logic         ext_master_req, ext_master_we;
  logic [31:0]  ext_master_addr_read;
  logic [31:0]  ext_master_addr_write;
  logic [31:0]  ext_master_wdata;
  logic [31:0]  ext_master_rdata;
  logic         ext_master_read_done;
  logic         ext_master_write_done;
  logic         busy;

  fuzz_master_arbiter #(
    .NUM_REQ        (4),
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .req_valid             (req_valid),
    .req_we                (req_we),
    .req_addr              (req_addr),
    .req_wdata             (req_wdata),
    .req_grant             (req_grant),
    .req_done              (req_done),
    .req_err               (req_err),
    .req_rdata             (req_rdata),
    .ext_master_req        (ext_master_req),
    .ext_master_we         (ext_master_we),
    .ext_master_addr_read  (ext_master_addr_read),
    .ext_master_addr_write (ext_master_addr_write),
    .ext_master_wdata      (ext_master_wdata),
    .ext_master_rdata      (ext_master_rdata),
    .ext_master_read_done  (ext_master_read_done),
    .ext_master_write_done (ext_master_write_done),
    .busy                  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    logic [3:0]  done;
    logic [3:0]  err;
    logic [31:0] rdata;
  } cmp_t;

  gnt_t gq[$];
  cmp_t cq[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [31:0] t_addr  [4];
  logic [31:0] t_wdata [4];
  logic        t_we    [4];

  int          resp_delay;
  int          spur_at;
  logic [31:0] resp_rdata;
  logic        idle_spur;
  int          exp_gap;
  int          cmpl_cyc;
  logic [31:0] last_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h",
               name, act, exp);
    end
  endtask

  task automatic load_ops();
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32]  = t_addr[i];
      req_wdata[i*32 +: 32] = t_wdata[i];
      req_we[i]             = t_we[i];
    end
  endtask

  task automatic expect_grant(input int idx);
    gnt_t g;
    g.idx   = idx;
    g.we    = t_we[idx];
    g.addr  = t_addr[idx];
    g.wdata = t_wdata[idx];
    gq.push_back(g);
  endtask

  task automatic expect_txn(input int idx,
                            input bit err);
    cmp_t c;
    expect_grant(idx);
    c.done = err ? 4'b0 : 4'(1 << idx);
    c.err  = err ? 4'(1 << idx) : 4'b0;
    if (!err && !t_we[idx]) last_rdata = resp_rdata;
    c.rdata = last_rdata;
    cq.push_back(c);
  endtask

  // Hold mask until n completions seen.
  task automatic run(input logic [3:0] mask,
                     input int n,
                     input int drop_at);
    int cnt = 0;
    int k = 0;
    req_valid = mask;
    while (cnt < n && k < 200) begin
      @(negedge clk);
      k++;
      if (drop_at > 0 && k == drop_at)
        req_valid = '0;
      if (req_done != 0 || req_err != 0) cnt++;
    end
    req_valid = '0;
    if (cnt < n) begin
      n_chk++;
      n_fail++;
      $display("FAIL run_budget: actual=%0d required=%0d",
               cnt, n);
    end
  endtask

  // Bus responder: k counts WAIT cycles.
  initial begin : responder
    int   k;
    logic in_txn;
    logic r_we;
    k = 0;
    in_txn = 1'b0;
    r_we = 1'b0;
    ext_master_rdata      = '0;
    ext_master_read_done  = 1'b0;
    ext_master_write_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ext_master_read_done  = idle_spur;
      ext_master_write_done = idle_spur;
      if (ext_master_req) begin
        if (!in_txn) begin
          in_txn = 1'b1;
          k = 0;
          r_we = ext_master_we;
        end else begin
          k++;
        end
        if (k > 0 && k == spur_at) begin
          if (r_we) ext_master_read_done = 1'b1;
          else      ext_master_write_done = 1'b1;
        end
        if (k > 0 && k == resp_delay) begin
          ext_master_rdata = resp_rdata;
          if (r_we) ext_master_write_done = 1'b1;
          else      ext_master_read_done = 1'b1;
          cmpl_cyc = cyc;
        end
      end else begin
        in_txn = 1'b0;
      end
    end
  end

  initial begin : monitor
    gnt_t cur;
    cmp_t c;
    logic prev_req;
    int   last_issue;
    int   prev_gap;
    cur = '{0, 1'b0, 32'h0, 32'h0};
    prev_req = 1'b0;
    last_issue = 0;
    prev_gap = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ext_master_req && !prev_req) begin
          if (gq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_grant: actual=0x%0h required=none",
                     req_grant);
          end else begin
            cur = gq.pop_front();
            chk("grant", 64'(req_grant),
                64'(1) << cur.idx);
            chk("issue_we", 64'(ext_master_we),
                64'(cur.we));
            chk("issue_addr_read",
                64'(ext_master_addr_read),
                64'(cur.addr));
            chk("issue_addr_write",
                64'(ext_master_addr_write),
                64'(cur.addr));
            chk("issue_wdata", 64'(ext_master_wdata),
                64'(cur.wdata));
            if (exp_gap > 0 && prev_gap > 0)
              chk("issue_gap", 64'(cyc - last_issue),
                  64'(exp_gap));
          end
          last_issue = cyc;
          prev_gap = exp_gap;
        end else if (ext_master_req) begin
          chk("wait_addr_write",
              64'(ext_master_addr_write),
              64'(cur.addr));
          chk("wait_wdata", 64'(ext_master_wdata),
              64'(cur.wdata));
        end
        if (req_done != 0 || req_err != 0) begin
          if (cq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_done: actual done=0x%0h err=0x%0h required=none",
                     req_done, req_err);
          end else begin
            c = cq.pop_front();
            chk("req_done", 64'(req_done), 64'(c.done));
            chk("req_err", 64'(req_err), 64'(c.err));
            chk("req_rdata", 64'(req_rdata),
                64'(c.rdata));
            chk("done_req_low", 64'(ext_master_req),
                64'(0));
            if (req_done != 0)
              chk("done_latency", 64'(cyc - cmpl_cyc),
                  64'(1));
`ifdef FUZZ_ARB_TIMEOUT_EN
            if (req_err != 0)
              chk("err_latency", 64'(cyc - last_issue),
                  64'(9));
`endif
          end
        end
      end
      prev_req = ext_master_req;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n      = 1'b0;
    req_valid  = '0;
    req_we     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    idle_spur  = 1'b0;
    resp_delay = 0;
    spur_at    = 0;
    resp_rdata = '0;
    exp_gap    = 0;
    cmpl_cyc   = 0;
    last_rdata = '0;
    t_addr[0] = 32'h1000_0000; t_wdata[0] = 32'h5500_0000; t_we[0] = 1'b1;
    t_addr[1] = 32'h2000_0004; t_wdata[1] = 32'h5500_0001; t_we[1] = 1'b0;
    t_addr[2] = 32'h3000_0010; t_wdata[2] = 32'hA000_0111; t_we[2] = 1'b1;
    t_addr[3] = 32'h4000_0020; t_wdata[3] = 32'h5500_0003; t_we[3] = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(req_grant), 64'(0));
    chk("rst_done", 64'(req_done), 64'(0));
    chk("rst_err", 64'(req_err), 64'(0));
    chk("rst_rdata", 64'(req_rdata), 64'(0));
    chk("rst_req", 64'(ext_master_req), 64'(0));
    chk("rst_we", 64'(ext_master_we), 64'(0));
    chk("rst_addr_r", 64'(ext_master_addr_read), 64'(0));
    chk("rst_addr_w", 64'(ext_master_addr_write), 64'(0));
    chk("rst_wdata", 64'(ext_master_wdata), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    load_ops();
    repeat (2) @(negedge clk);

    // dones while idle must be ignored
    idle_spur = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_done", 64'(req_done), 64'(0));
    idle_spur = 1'b0;
    repeat (2) @(negedge clk);

    // requester 2 write, operands mutated after capture
    resp_delay = 3;
    resp_rdata = 32'hDEAD_BEEF;
    expect_txn(2, 1'b0);
    fork
      run(4'b0100, 1, 0);
      begin
        repeat (2) @(negedge clk);
        req_addr[64 +: 32]  = 32'hFFFF_FFFF;
        req_wdata[64 +: 32] = 32'h0;
      end
    join
    load_ops();
    repeat (3) @(negedge clk);

    // all valid from rr_ptr=3
    resp_delay = 1;
    resp_rdata = 32'h0BAD_F00D;
    exp_gap = 4;
    expect_txn(3, 1'b0);
    expect_txn(0, 1'b0);
    expect_txn(1, 1'b0);
    expect_txn(2, 1'b0);
    expect_txn(3, 1'b0);
    run(4'b1111, 5, 0);
    exp_gap = 0;
    repeat (3) @(negedge clk);

    // requester 1 read with stray write_done
    resp_delay = 3;
    spur_at = 1;
    resp_rdata = 32'h63A9_1243;
    expect_txn(1, 1'b0);
    run(4'b0010, 1, 0);
    spur_at = 0;
    repeat (3) @(negedge clk);

    // requester 0 write, valid dropped mid-flight
    resp_rdata = 32'h1234_5678;
    expect_txn(0, 1'b0);
    run(4'b0001, 1, 3);
    repeat (3) @(negedge clk);

    // reset during WAIT
    resp_delay = 0;
    expect_grant(3);
    req_valid = 4'b1000;
    for (int k = 0; k < 20 && !ext_master_req; k++)
      @(negedge clk);
    chk("rst_setup_req", 64'(ext_master_req), 64'(1));
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 64'(ext_master_req), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_grant", 64'(req_grant), 64'(0));
    chk("mid_rst_done", 64'(req_done), 64'(0));
    chk("mid_rst_err", 64'(req_err), 64'(0));
    chk("mid_rst_rdata", 64'(req_rdata), 64'(0));
    req_valid = '0;
    last_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // all valid from rr_ptr=0
    resp_delay = 1;
    resp_rdata = 32'h7777_0001;
    exp_gap = 4;
    expect_txn(0, 1'b0);
    expect_txn(1, 1'b0);
    expect_txn(2, 1'b0);
    expect_txn(3, 1'b0);
    expect_txn(0, 1'b0);
    run(4'b1111, 5, 0);
    exp_gap = 0;
    repeat (3) @(negedge clk);

`ifdef FUZZ_ARB_TIMEOUT_EN
    // no response: both time out, rr_ptr=1
    resp_delay = 0;
    expect_txn(1, 1'b1);
    expect_txn(0, 1'b1);
    run(4'b0011, 2, 0);
    repeat (3) @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("grant_q_empty", 64'(gq.size()), 64'(0));
    chk("cmpl_q_empty", 64'(cq.size()), 64'(0));
    chk("end_busy", 64'(busy), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fuzz_master_arbiter.md
FUZZ_MASTER_ARBITER -- requirements
Module: fuzz_master_arbiter

Interface
REQ-001 SHALL have parameters: NUM_REQ, default 4, number of requesters; ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width; TIMEOUT_CYCLES, default 255, WAIT-state cycle limit.
REQ-002 SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  async active-low reset.
- req_valid  in  NUM_REQ  per-requester transaction request.
- req_we  in  NUM_REQ  per-requester write (1) / read (0).
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i.
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_grant  out  NUM_REQ  one-hot owner of the bus.
- req_done  out  NUM_REQ  one-cycle completion pulse to the owner.
- req_err  out  NUM_REQ  one-cycle timeout pulse to the owner.
- req_rdata  out  DATA_WIDTH  captured read data, valid with req_done.
- ext_master_req  out  1  to Wishbone master interface.
- ext_master_we  out  1  write enable.
- ext_master_addr_read  out  ADDR_WIDTH  read address.
- ext_master_addr_write  out  ADDR_WIDTH  write address.
- ext_master_wdata  out  DATA_WIDTH  write data.
- ext_master_rdata  in  DATA_WIDTH  read data.
- ext_master_read_done  in  1  read completion.
- ext_master_write_done  in  1  write completion.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-004 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-005 In IDLE, if any req_valid is set, SHALL pick the first set bit at or after rr_ptr (cyclic) and register owner index, we, addr and wdata. SHALL move to ISSUE next cycle with req_grant one-hot on the owner.
REQ-006 In ISSUE and WAIT, SHALL drive ext_master_req=1, ext_master_we=captured we, and the captured addr on both address outputs. ext_master_wdata SHALL carry the captured wdata. ISSUE SHALL last exactly one cycle, then go to WAIT.
REQ-007 In WAIT, completion is write_done when we=1 and read_done when we=0. The opposite-type done SHALL be ignored.
REQ-008 On completion, SHALL enter DONE: req_done[owner] pulses one cycle and req_rdata holds ext_master_rdata sampled at read_done (unchanged for writes). ext_master_req SHALL drop in DONE.
REQ-009 DONE SHALL last one cycle and then go to IDLE. rr_ptr SHALL become (owner+1) mod NUM_REQ, and req_grant SHALL clear.
REQ-010 Latency: req_valid seen in IDLE at cycle N gives ext_master_req at N+1. Completion at cycle M gives req_done at M+1. Minimum back-to-back spacing is 4 cycles.
REQ-011 Requesters SHALL hold req_valid and operands until req_done. Dropping req_valid mid-transaction SHALL NOT abort it; req_done still pulses.
REQ-012 Changes to req_addr/req_wdata after capture SHALL have no effect on the bus.
REQ-013 Done inputs arriving in IDLE, ISSUE or DONE SHALL be ignored.
REQ-014 A single active requester SHALL be re-granted after every DONE.
REQ-015 Index arithmetic SHALL be $clog2(NUM_REQ) bits with explicit wrap at NUM_REQ, including non-power-of-two NUM_REQ.

Reset
REQ-016 On rst_n low, SHALL set state IDLE, rr_ptr 0, owner 0 and the timeout counter 0. All outputs SHALL be 0, including req_rdata and ext_master_*.
REQ-017 Reset asserted mid-transaction SHALL drop ext_master_req immediately, with no req_done or req_err pulse.

Configuration
REQ-018 With FUZZ_ARB_TIMEOUT_EN defined:
- a counter runs in WAIT;
- on reaching TIMEOUT_CYCLES with no completion, SHALL pulse req_err[owner] and drop ext_master_req;
- SHALL go to DONE without req_done, then rotate rr_ptr normally.
REQ-019 Without FUZZ_ARB_TIMEOUT_EN, WAIT SHALL wait indefinitely, req_err SHALL be tied 0, and no counter SHALL be synthesized.

Structure
REQ-020 The state enum (arb_state_t) and the default-parameter constants SHALL live in shared package fuzz_pkg.
REQ-021 Selection logic SHALL be sub-module fuzz_rr_picker: inputs req_valid and rr_ptr, outputs index and found flag, purely combinational.

Verification
REQ-022 Reset with all inputs 0 -> all outputs 0, busy 0.
REQ-023 Requester 2 writes addr 0x3000_0010 data 0xA000_0111; write_done 3 cycles after ISSUE -> ext_master_addr_write=0x3000_0010, req_done[2] pulses 1 cycle later, rr_ptr=3.
REQ-024 All four requesters valid continuously -> grant order 0,1,2,3,0, with no requester granted twice before the others.
REQ-025 Requester 1 reads; read_done with rdata 0x63A9_1243 -> req_rdata=0x63A9_1243 in the req_done[1] cycle. A write_done pulse during that WAIT is ignored.
REQ-026 With FUZZ_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, no done -> req_err[owner] after 8 WAIT cycles, no req_done, next requester granted.
REQ-027 rst_n pulsed low during WAIT -> ext_master_req=0 asynchronously, no done pulse, and arbitration restarts from requester 0.
